// File: rtl/mem_port_pkg.sv
// Shared definitions for the multicycle CPU memory port: FSM encodings,
// timeout default, and the opcode field/constants the control FSM decodes.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TIMEOUT_DEF = 255;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/mem_wait_timer.sv
// 8-bit wait counter for an outstanding memory access; flags the cycle in
// which the access has been pending for TIMEOUT cycles.
module mem_wait_timer
  import mem_port_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // cnt holds the number of BUSY cycles already completed, so the
  // TIMEOUT-th pending cycle is the one where cnt == TIMEOUT-1.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 8'd1;
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory port controller: request/ack handshake to unified memory, owns IR
// and MDR, and stalls the control FSM until each access completes.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ior_d,
  input  logic              ir_write,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] b_data,
  output logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [DATA_W-1:0] mdr,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  state_t            state, state_nxt;
  logic              req, misal, we_q, irw_q, expired, busy;
  logic [DATA_W-1:0] addr_sel;

  assign req      = mem_read | mem_write;
  assign addr_sel = ior_d ? alu_out : pc;
  assign misal    = |addr_sel[1:0];
  assign busy     = (state == BUSY);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!busy),
    .en      (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    m_req     = 1'b0;
    case (state)
      IDLE: if (req) begin
        stall     = 1'b1;
        state_nxt = misal ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        m_req = 1'b1;
        if (m_ack || expired) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write wins when both strobes are high; a misaligned address is never
  // latched, so m_addr only ever carries word-aligned values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr  <= '0;
      m_wdata <= '0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      ir      <= '0;
      mdr     <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (misal) begin
            err <= 1'b1;
          end else begin
            m_addr  <= addr_sel;
            m_wdata <= b_data;
            we_q    <= mem_write;
            irw_q   <= ir_write;
          end
        end
        BUSY: begin
          if (m_ack) begin
            if (!we_q) begin
              if (irw_q) ir  <= m_rdata;
              else       mdr <= m_rdata;
            end
          end else if (expired) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_we   = we_q & busy;
  assign opcode = ir[OP_HI:OP_LO];

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: a small model pushes expected IR/MDR/err
// and cycle counts per access; they are popped and checked at completion.
module tb_mem_port_ctrl;
  import mem_port_pkg::*;

  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read = 0, mem_write = 0, ior_d = 0, ir_write = 0;
  logic [DW-1:0] pc = 0, alu_out = 0, b_data = 0, m_rdata = 0;
  logic          m_ack = 0;
  logic          stall, err, m_req, m_we;
  logic [DW-1:0] ir, mdr, m_addr, m_wdata;
  logic [5:0]    opcode;

  mem_port_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .ior_d(ior_d), .ir_write(ir_write),
    .pc(pc), .alu_out(alu_out), .b_data(b_data),
    .stall(stall), .ir(ir), .opcode(opcode), .mdr(mdr), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        err;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ir_m = 0, mdr_m = 0;
  logic        err_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ctl"}, {28'b0, m_req, m_we, stall, err}, 32'h0);
    chk({tag, ".ir"}, ir, 32'h0);
    chk({tag, ".mdr"}, mdr, 32'h0);
    chk({tag, ".addr"}, m_addr, 32'h0);
    chk({tag, ".wdata"}, m_wdata, 32'h0);
    chk({tag, ".opc"}, {26'b0, opcode}, 32'h0);
  endtask

  // ack_at: m_req cycle carrying m_ack (1 = first); 0 = memory never answers.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic iord, input logic irw,
                        input logic [31:0] pcv, input logic [31:0] aluv,
                        input logic [31:0] bv, input int ack_at,
                        input logic [31:0] rdata);
    exp_t        e;
    logic [31:0] a;
    int          stalls = 0;
    int          reqs = 0;
    bit          done = 0;
    a = iord ? aluv : pcv;
    e.tag = tag; e.stalls = 1; e.reqs = 0;
    if (a[1:0] != 2'b00) begin
      err_m = 1'b1;
    end else if (ack_at == 0) begin
      err_m = 1'b1; e.stalls = 1 + TO; e.reqs = TO;
    end else begin
      e.stalls = 1 + ack_at; e.reqs = ack_at;
      if (!wr) begin
        if (irw) ir_m = rdata;
        else     mdr_m = rdata;
      end
    end
    e.ir = ir_m; e.mdr = mdr_m; e.err = err_m;
    sb.push_back(e);

    mem_read = rd; mem_write = wr; ior_d = iord; ir_write = irw;
    pc = pcv; alu_out = aluv; b_data = bv;
    #1;
    for (int c = 0; c < 64; c++) begin
      if (!stall) begin done = 1; break; end
      stalls++;
      if (m_req) begin
        reqs++;
        chk({tag, ".m_addr"}, m_addr, a);
        chk({tag, ".m_we"}, {31'b0, m_we}, {31'b0, wr});
        if (wr) chk({tag, ".m_wdata"}, m_wdata, bv);
        if (reqs == ack_at) begin m_ack = 1'b1; m_rdata = rdata; end
      end
      @(posedge clk); #1;
      m_ack = 1'b0; m_rdata = 32'h0;
      #1;
    end

    e = sb.pop_front();
    chk({e.tag, ".reached_done"}, {31'b0, done}, 32'd1);
    chk({e.tag, ".stall_cycles"}, stalls, e.stalls);
    chk({e.tag, ".req_cycles"}, reqs, e.reqs);
    chk({e.tag, ".ir"}, ir, e.ir);
    chk({e.tag, ".opcode"}, {26'b0, opcode}, {26'b0, e.ir[31:26]});
    chk({e.tag, ".mdr"}, mdr, e.mdr);
    chk({e.tag, ".err"}, {31'b0, err}, {31'b0, e.err});
    chk({e.tag, ".done_req"}, {31'b0, m_req}, 32'h0);

    // Request still held through DONE; it must not be captured a second time.
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; ior_d = 0; ir_write = 0;
    #1;
    chk({e.tag, ".idle_after"}, {30'b0, stall, m_req}, 32'h0);
  endtask

  initial begin
    #3;
    chk_zero("reset");
    @(posedge clk); #1; rst_n = 1'b1; #1;

    access("fetch",    1, 0, 0, 1, 32'h40, 32'h0,   32'h0,        1, 32'h8C220004);
    chk("fetch.opc_lw", {26'b0, opcode}, {26'b0, OP_LW});
    access("load",     1, 0, 1, 0, 32'h44, 32'h100, 32'h0,        4, 32'hDEADBEEF);
    access("store",    0, 1, 1, 0, 32'h48, 32'h200, 32'h12345678, 3, 32'hFFFFFFFF);
    access("rw_both",  1, 1, 1, 0, 32'h4C, 32'h204, 32'hCAFEF00D, 2, 32'h55555555);

    // Ack pulse while idle must be ignored.
    m_ack = 1'b1; m_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1; m_ack = 1'b0; m_rdata = 32'h0; #1;
    chk("stray_ack.mdr", mdr, mdr_m);
    chk("stray_ack.ir", ir, ir_m);

    access("misalign", 1, 0, 1, 0, 32'h50, 32'h102, 32'h0,        1, 32'h11111111);
    access("fetch2",   1, 0, 0, 1, 32'h54, 32'h0,   32'h0,        2, 32'hAC430008);

    // Abandon an access in BUSY with an asynchronous reset.
    mem_read = 1; ir_write = 1; pc = 32'h58;
    @(posedge clk); #2;
    chk("rst_mid.busy_req", {31'b0, m_req}, 32'd1);
    rst_n = 1'b0; mem_read = 0; ir_write = 0;
    #1;
    chk_zero("rst_mid");
    ir_m = 0; mdr_m = 0; err_m = 0;
    @(posedge clk); #1; rst_n = 1'b1; #1;

    access("fetch_rst", 1, 0, 0, 1, 32'h5C, 32'h0,  32'h0,        1, 32'h10220003);
    access("timeout",   1, 0, 1, 0, 32'h60, 32'h300, 32'h0,       0, 32'h0);
    access("fetch_err", 1, 0, 0, 1, 32'h64, 32'h0,  32'h0,        1, 32'h08000010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Memory port controller for the multicycle CPU. It sits between the control-unit FSM and the unified instruction/data memory. It consumes the control outputs MemRead, MemWrite, IorD and IRWrite, runs a request/acknowledge handshake with a variable-latency memory, and owns the Instruction Register (IR) and Memory Data Register (MDR). It returns `stall` so the control FSM holds its state until each access completes, and it drives `opcode` back to the control FSM.

## Interface
Parameters:
- `DATA_W`, 32: data and address width.
- `TIMEOUT`, 255: maximum BUSY cycles without `m_ack` before the access is aborted (1..255).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `mem_read`  in  1  read request from the control FSM.
- `mem_write`  in  1  write request from the control FSM.
- `ior_d`  in  1  address select: 0 = `pc`, 1 = `alu_out`.
- `ir_write`  in  1  the read data is an instruction; load IR instead of MDR.
- `pc`  in  DATA_W  program counter.
- `alu_out`  in  DATA_W  ALUOut register, used for data addresses.
- `b_data`  in  DATA_W  B register, the store data.
- `stall`  out  1  control FSM must not advance its state this cycle.
- `ir`  out  DATA_W  instruction register.
- `opcode`  out  6  `ir[31:26]`, combinational, to the control FSM.
- `mdr`  out  DATA_W  memory data register.
- `err`  out  1  sticky error flag, set on timeout or misaligned access.
- `m_req`  out  1  memory request.
- `m_we`  out  1  write enable, valid while `m_req` is high.
- `m_addr`  out  DATA_W  byte address, word-aligned.
- `m_wdata`  out  DATA_W  write data.
- `m_rdata`  in  DATA_W  read data, valid in the cycle `m_ack` is high.
- `m_ack`  in  1  memory completion, one cycle per access.

## Operation
- State machine with three states: IDLE, BUSY, DONE.
- IDLE:
  - If `mem_read | mem_write`: latch the address (`ior_d ? alu_out : pc`), `b_data`, `m_we = mem_write`, and the IR/MDR target (`ir_write`). Next state BUSY.
  - If both `mem_read` and `mem_write` are high, the access is a write. No error is raised.
  - Misaligned address (`addr[1:0] != 0`): set `err`, issue no request, next state DONE.
- BUSY:
  - `m_req = 1`; `m_addr`, `m_we` and `m_wdata` are held stable from the latches.
  - Wait counter increments once per cycle.
  - On `m_ack`:
    - Read with `ir_write` latched: `ir <= m_rdata`.
    - Read without `ir_write`: `mdr <= m_rdata`.
    - Write: no register update.
    - Next state DONE.
  - Counter reaches TIMEOUT without `m_ack`: set `err`, leave IR and MDR unchanged, next state DONE.
- DONE:
  - Unconditionally return to IDLE.
  - No new access is accepted in DONE, so the same request cannot be captured twice.
- `stall` (combinational) = (IDLE & (`mem_read | mem_write`)) | BUSY. It is 0 in DONE.
- `m_ack` outside BUSY is ignored.
- `err` is cleared only by reset.

## Timing
- Reset values: state IDLE; `m_req`, `m_we`, `stall`, `err` = 0; `ir`, `mdr`, `m_addr`, `m_wdata` = 0; counter = 0.
- Reset mid-access drops `m_req` immediately (asynchronous). The memory must tolerate an abandoned request.
- Access sequence: request seen in cycle N (IDLE, `stall = 1`) → `m_req` high from cycle N+1 → ack in cycle N+k (k ≥ 1; `m_ack` may come in the first `m_req` cycle) → DONE in cycle N+k+1 (`stall = 0`, IR/MDR already updated, `opcode` valid) → the control FSM advances at the end of that cycle.
- Minimum access cost: 3 cycles, of which 2 stall.
- Timeout: DONE in cycle N+TIMEOUT+1.
- `m_req` deasserts in the cycle after `m_ack`.

## Structure
- Shared package `mem_port_pkg` holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - default TIMEOUT;
  - opcode field bounds 31:26;
  - the opcode constants 6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, which the control FSM uses as well.
- One sub-module, `mem_wait_timer`: an 8-bit counter with clear, enable, and a `expired` output at TIMEOUT.

## Test plan
- Instruction fetch, `mem_read=1 ir_write=1 ior_d=0 pc=0x40`, memory acks 1 cycle after `m_req` with 0x8C220004 → `m_addr=0x40`, `stall` high 2 cycles, `ir=0x8C220004` and `opcode=6'b100011` in DONE.
- Load, `ior_d=1 alu_out=0x100`, ack after 4 cycles with 0xDEADBEEF → `mdr=0xDEADBEEF`, `ir` unchanged, `stall` high 5 cycles.
- Store, `mem_write=1 alu_out=0x200 b_data=0x12345678` → `m_we=1`, `m_wdata=0x12345678` stable until ack; `ir` and `mdr` unchanged.
- No ack with TIMEOUT=8 → DONE reached 9 cycles after the request; `err=1` stays set; `mdr` unchanged.
- Misaligned read, `alu_out=0x102` → `m_req` never asserted, `err=1`, `stall` low in the following cycle.
- `rst_n` pulled low in BUSY → `m_req=0` and all outputs 0 asynchronously; the next fetch after reset completes normally.
